pc_fold_collector: RTL and testbench

- Sits directly downstream of the per-neuron popcount stage of the folded binary FC layer.
- Each accepted beat carries DIM_OUT/FOLD popcounts, one group of output neurons.
- The block assembles FOLD consecutive beats into a full DIM_OUT vector, binarizes each neuron against a per-neuron threshold, and presents raw popcounts plus sign bits to the next layer over a valid/ready handshake.

---
 rtl/pc_fold_collector.sv | 128 ++++++++++++
 tb/tb_pc_fold_collector.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fold_collector.sv
// pc_fold_collector
// Collects FOLD consecutive popcount beats of G neurons each into one full
// DIM_OUT-wide vector. Each neuron is binarized against its threshold as its
// group is captured. The finished vector is then held for the next layer.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and data stable until that edge. ready never
// depends combinationally on valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the partial vector (ignored while holding)
//   in_valid   beat valid
//   in_ready   high while collecting
//   pc_in      G x W popcounts; lane j is neuron fold_idx*G+j
//   thr        DIM_OUT x W thresholds, sampled when each group is captured
//   out_valid  full vector available (high while holding)
//   out_ready  consumer accepts the held vector
//   out_pc     DIM_OUT x W raw popcounts, registered
//   out_bits   DIM_OUT binarized activations (pc >= thr), registered
//   fold_idx   index of the next group expected
module pc_fold_collector #(
   parameter  int DIM_IN     = 110,
   parameter  int DIM_OUT    = 16,
   parameter  int FOLD       = 4,
   parameter  int LOG_DIM_IN = 7,
   localparam int W          = LOG_DIM_IN + 1,
   localparam int G          = DIM_OUT / FOLD,
   localparam int FI_W       = (FOLD > 1) ? $clog2(FOLD) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [G*W-1:0]       pc_in,
   input  logic [DIM_OUT*W-1:0] thr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DIM_OUT*W-1:0] out_pc,
   output logic [DIM_OUT-1:0]   out_bits,
   output logic [FI_W-1:0]      fold_idx
);

   // Elaboration-time sanity checks on the parameter set.
   if ((DIM_OUT % FOLD) != 0) begin : g_bad_fold
      $error("DIM_OUT must be a multiple of FOLD");
   end
   if ((1 << LOG_DIM_IN) < DIM_IN) begin : g_bad_width
      $error("LOG_DIM_IN too small for DIM_IN");
   end

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [FI_W-1:0] fold_q, fold_d;
   logic            accept;

   // The outputs are decoded straight from the state register, so they are
   // glitch-free and are available right after reset.
   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == HOLD);
   assign fold_idx  = fold_q;

   // clear has priority over a beat arriving in the same cycle.
   assign accept = in_valid && in_ready && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         fold_q  <= '0;
      end else begin
         state_q <= state_d;
         fold_q  <= fold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fold_d  = fold_q;
      case (state_q)
         COLLECT: begin
            if (clear) begin
               fold_d = '0;
            end else if (accept) begin
               if (fold_q == FI_W'(FOLD - 1)) begin
                  fold_d  = '0;
                  state_d = HOLD;
               end else begin
                  fold_d = fold_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
            fold_d  = '0;
         end
      endcase
   end

   // Every neuron slot belongs to exactly one group. A slot is only written
   // when its own group is accepted. The previous vector therefore stays
   // visible after the handshake, until the new beats overwrite it group by
   // group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pc   <= '0;
         out_bits <= '0;
      end else begin
         for (int n = 0; n < DIM_OUT; n++) begin
            if (accept && (fold_q == FI_W'(n / G))) begin
               out_pc[n*W +: W] <= pc_in[(n % G)*W +: W];
               out_bits[n]      <= (pc_in[(n % G)*W +: W] >= thr[n*W +: W]);
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_fold_collector.sv
// Testbench for pc_fold_collector.
// The inputs are driven 1 time unit after each rising edge. The outputs are
// compared on the falling edge against a behavioural model, and each
// delivered vector is checked against an expected queue.
module tb_pc_fold_collector;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int G  = 4;
  localparam int FO = 4;
  localparam int VW = N*W + N;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  logic [G*W-1:0] pc_in;
  logic [N*W-1:0] thr;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_pc;
  logic [N-1:0]   out_bits;
  logic [1:0]     fold_idx;

  logic [W-1:0] pc_v [G];
  logic [W-1:0] thr_v [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    pc_in = '0;
    thr   = '0;
    for (int j = 0; j < G; j++) pc_in[j*W +: W] = pc_v[j];
    for (int n = 0; n < N; n++) thr[n*W +: W] = thr_v[n];
  end

  pc_fold_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .thr       (thr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_bits  (out_bits),
    .fold_idx  (fold_idx)
  );

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps a held flag, the next group index and the neuron arrays.
  bit           m_hold;
  int           m_idx;
  logic [W-1:0] m_pc [N];
  bit           m_bits [N];
  logic [VW-1:0] exp_q[$];

  function automatic logic [N*W-1:0] pack_pc();
    logic [N*W-1:0] v;
    for (int n = 0; n < N; n++) v[n*W +: W] = m_pc[n];
    return v;
  endfunction

  function automatic logic [N-1:0] pack_bits();
    logic [N-1:0] v;
    for (int n = 0; n < N; n++) v[n] = m_bits[n];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      m_idx  = 0;
      for (int n = 0; n < N; n++) begin
        m_pc[n]   = '0;
        m_bits[n] = 1'b0;
      end
      exp_q.delete();
    end else if (!m_hold) begin
      if (clear) begin
        m_idx = 0;
      end else if (in_valid) begin
        for (int j = 0; j < G; j++) begin
          m_pc[m_idx*G + j]   = pc_v[j];
          m_bits[m_idx*G + j] = (pc_v[j] >= thr_v[m_idx*G + j]);
        end
        m_idx++;
        if (m_idx == FO) begin
          m_idx  = 0;
          m_hold = 1'b1;
          exp_q.push_back({pack_pc(), pack_bits()});
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  logic [VW-1:0] popped;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("out_valid", VW'(out_valid), VW'(m_hold));
      check("in_ready", VW'(in_ready), VW'(!m_hold));
      check("fold_idx", VW'(fold_idx), VW'(m_idx));
      check("out_pc", VW'(out_pc), VW'(pack_pc()));
      check("out_bits", VW'(out_bits), VW'(pack_bits()));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_vector", VW'(1), VW'(0));
        end else begin
          popped = exp_q.pop_front();
          check("sb_vector", {out_pc, out_bits}, popped);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input int base);
    for (int j = 0; j < G; j++) pc_v[j] = W'(base + j);
  endtask

  logic [N*W-1:0] exp_pc;
  logic [N*W-1:0] saved_pc;
  logic [N-1:0]   saved_bits;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int j = 0; j < G; j++) pc_v[j] = '0;
    for (int n = 0; n < N; n++) thr_v[n] = '0;
    repeat (3) tick();
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_in_ready", VW'(in_ready), VW'(1));
    check("rst_fold_idx", VW'(fold_idx), VW'(0));
    check("rst_out_pc", VW'(out_pc), VW'(0));
    check("rst_out_bits", VW'(out_bits), VW'(0));
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: all 55 against thresholds of 55
    for (int n = 0; n < N; n++) thr_v[n] = 8'd55;
    for (int j = 0; j < G; j++) pc_v[j] = 8'd55;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check("t1_out_valid", VW'(out_valid), VW'(1));
    check("t1_in_ready", VW'(in_ready), VW'(0));
    check("t1_out_bits", VW'(out_bits), VW'(16'hFFFF));
    check("t1_out_pc", VW'(out_pc), VW'({16{8'd55}}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_released", VW'(out_valid), VW'(0));

    // 2: ramp values against threshold 8, continuous ready
    for (int n = 0; n < N; n++) thr_v[n] = 8'd8;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_group(c*G);
      tick();
    end
    for (int n = 0; n < N; n++) exp_pc[n*W +: W] = W'(n);
    check("t2_out_pc", VW'(out_pc), VW'(exp_pc));
    check("t2_out_bits", VW'(out_bits), VW'(16'hFF00));
    set_group(0);
    tick();
    check("t2_hold_done_fold", VW'(fold_idx), VW'(0));
    tick();
    check("t2_cycle5_accept", VW'(fold_idx), VW'(1));
    in_valid = 1'b0; out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t2_clear_fold", VW'(fold_idx), VW'(0));

    // 3: compare boundaries in group 0
    for (int n = 0; n < N; n++) thr_v[n] = 8'd0;
    thr_v[1] = 8'd111;
    thr_v[2] = 8'd110;
    pc_v[0] = 8'd0; pc_v[1] = 8'd110; pc_v[2] = 8'd110; pc_v[3] = 8'd0;
    in_valid = 1'b1;
    tick();
    set_group(0);
    repeat (3) tick();
    check("t3_boundary_bits", VW'(out_bits[2:0]), VW'(3'b101));

    // 4: backpressure with a producer that keeps offering beats
    saved_pc   = out_pc;
    saved_bits = out_bits;
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < G; j++) pc_v[j] = W'($urandom_range(0, 255));
      tick();
      check("t4_hold_valid", VW'(out_valid), VW'(1));
      check("t4_hold_fold", VW'(fold_idx), VW'(0));
    end
    check("t4_stable_pc", VW'(out_pc), VW'(saved_pc));
    check("t4_stable_bits", VW'(out_bits), VW'(saved_bits));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("t4_accept_after_release", VW'(fold_idx), VW'(1));

    // 5: clear together with a valid beat, then a fresh vector
    tick();
    check("t5_two_beats", VW'(fold_idx), VW'(2));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clear_fold", VW'(fold_idx), VW'(0));
    check("t5_clear_no_hold", VW'(out_valid), VW'(0));
    for (int c = 0; c < 4; c++) begin
      set_group(100 + c*G);
      tick();
    end
    in_valid = 1'b0;
    for (int n = 0; n < N; n++) exp_pc[n*W +: W] = W'(100 + n);
    check("t5_fresh_pc", VW'(out_pc), VW'(exp_pc));
    clear = 1'b1;
    tick();
    check("t5_clear_in_hold", VW'(out_valid), VW'(1));
    out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    check("t5_delivered", VW'(out_valid), VW'(0));

    // 6: asynchronous reset in the middle of a vector
    in_valid = 1'b1;
    set_group(7);
    repeat (3) tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", VW'(out_valid), VW'(0));
    check("t6_async_fold", VW'(fold_idx), VW'(0));
    check("t6_async_bits", VW'(out_bits), VW'(0));
    #3 rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check("t6_recover_valid", VW'(out_valid), VW'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      for (int j = 0; j < G; j++)
        pc_v[j] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 110));
      if ($urandom_range(0, 49) == 0)
        for (int n = 0; n < N; n++) thr_v[n] = W'($urandom_range(0, 111));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
